// File: rtl/seg_result_decoder_pkg.sv
// Shared types and seven-segment code constants for the ALU result display decoder.
// Bit 7 of a segment pattern is the minus sign; 0x00 is a blank display.
package seg_pkg;

    localparam logic [7:0] zero         = 8'h3F;
    localparam logic [7:0] um           = 8'h06;
    localparam logic [7:0] dois         = 8'h5B;
    localparam logic [7:0] tres         = 8'h4F;
    localparam logic [7:0] menos_um     = 8'h86;
    localparam logic [7:0] menos_dois   = 8'hDB;
    localparam logic [7:0] menos_tres   = 8'hCF;
    localparam logic [7:0] menos_quatro = 8'hE6;
    localparam logic [7:0] apagado      = 8'h00;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_PRESENT
    } state_t;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] led;
    } seg_sample_t;

endpackage

// File: rtl/seg_result_decoder_seg7_to_val.sv
// Combinational lookup from a seven-segment pattern to a signed 3-bit value,
// flagging blank and out-of-table patterns.
module seg7_to_val
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [2:0] value,
    output logic       is_blank,
    output logic       is_invalid
);

    always_comb begin
        value      = '0;
        is_blank   = 1'b0;
        is_invalid = 1'b0;
        case (seg)
            zero:         value = 3'b000;
            um:           value = 3'b001;
            dois:         value = 3'b010;
            tres:         value = 3'b011;
            menos_um:     value = 3'b111;
            menos_dois:   value = 3'b110;
            menos_tres:   value = 3'b101;
            menos_quatro: value = 3'b100;
            apagado:      is_blank = 1'b1;
            default:      is_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_result_decoder.sv
// Monitors the ALU result display bus, waits for a stable {seg,led} sample,
// decodes and cross-checks it, and hands each new result downstream via valid/ready.
module seg_result_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NBITS_TOP     = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    input  logic [NBITS_TOP-1:0] seg_in,
    input  logic [NBITS_TOP-1:0] led_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [2:0]           out_value,
    output logic                 out_flow,
    output logic                 out_invalid,
    output logic                 out_mismatch,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

    state_t      state;
    seg_sample_t sample;
    seg_sample_t cand;
    seg_sample_t last;
    logic [CW-1:0] cnt;

    logic [2:0] dec_value;
    logic       dec_blank;
    logic       dec_invalid;

    seg7_to_val u_dec (
        .seg        (cand.seg),
        .value      (dec_value),
        .is_blank   (dec_blank),
        .is_invalid (dec_invalid)
    );

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_WAIT;
            sample       <= '0;
            cand         <= '0;
            last         <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_value    <= '0;
            out_flow     <= 1'b0;
            out_invalid  <= 1'b0;
            out_mismatch <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
        end else begin
            sample <= {seg_in[7:0], led_in[7:0]};
            case (state)
                S_WAIT: begin
                    if (sample != last) begin
                        cand  <= sample;
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (sample != cand) begin
                        cand <= sample;
                        cnt  <= '0;
                    end else if (cnt != LAST_CNT) begin
                        cnt <= cnt + CW'(1);
                    end else if (dec_blank) begin
                        // A settled blank is remembered so it is not re-settled, but never reported.
                        last  <= cand;
                        state <= S_WAIT;
                    end else begin
                        out_valid    <= 1'b1;
                        out_value    <= dec_value;
                        out_flow     <= cand.led[7];
                        out_invalid  <= dec_invalid;
                        out_mismatch <= !dec_invalid && (dec_value != cand.led[2:0]);
                        state        <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        last      <= cand;
                        out_valid <= 1'b0;
                        if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
                        if ((out_invalid || out_mismatch) && (err_count != '1))
                            err_count <= err_count + CNT_W'(1);
                        state <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule
